// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter, 8n1, LSB first, o clocks per bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits (8e1).
module uart_tx_fifo #(
  parameter int o     = 4,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in,
  input  logic       wr,
  output logic       full,
  output logic       busy,
  output logic       out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = (o > 1) ? $clog2(o) : 1;
  localparam logic [OW-1:0] OSC_LAST = OW'(o - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  state_t        r_state;
  logic [OW-1:0] r_osc;
  logic [2:0]    r_idx;
  logic [7:0]    r_sh;
  logic          r_out;
`ifdef UART_TX_PARITY_EN
  logic          r_par;
`endif

  state_t        w_stateNext;
  logic          w_pop;
  logic          w_push;
  logic [7:0]    w_head;
  logic [OW-1:0] w_oscNext;
  logic [2:0]    w_idxNext;
  logic [7:0]    w_shNext;
  logic          w_outNext;

  // full is judged on the pre-edge count, so a same-edge pop never admits a write
  assign full   = (r_count == CNT_FULL);
  assign busy   = (r_state != IDLE) || (r_count != '0);
  assign out    = r_out;
  assign w_push = wr && !full;
  assign w_head = r_mem[r_rdPtr];

  always_comb begin
    w_stateNext = r_state;
    w_pop       = 1'b0;
    w_oscNext   = r_osc + 1'b1;
    w_idxNext   = r_idx;
    w_shNext    = r_sh;
    w_outNext   = r_out;
    unique case (r_state)
      IDLE: begin
        w_oscNext = '0;
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_shNext    = w_head;
          w_outNext   = 1'b0;
          w_stateNext = START;
        end
      end
      START: begin
        if (r_osc == OSC_LAST) begin
          w_oscNext   = '0;
          w_idxNext   = 3'd0;
          w_outNext   = r_sh[0];
          w_stateNext = DATA;
        end
      end
      DATA: begin
        if (r_osc == OSC_LAST) begin
          w_oscNext = '0;
          if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_outNext   = r_par;
            w_stateNext = PAR;
`else
            w_outNext   = 1'b1;
            w_stateNext = STOP;
`endif
          end else begin
            w_idxNext = r_idx + 3'd1;
            w_shNext  = {1'b0, r_sh[7:1]};
            w_outNext = r_sh[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PAR: begin
        if (r_osc == OSC_LAST) begin
          w_oscNext   = '0;
          w_outNext   = 1'b1;
          w_stateNext = STOP;
        end
      end
`endif
      // a queued byte at the end of the stop bit starts the next frame with no gap
      STOP: begin
        if (r_osc == OSC_LAST) begin
          w_oscNext = '0;
          if (r_count != '0) begin
            w_pop       = 1'b1;
            w_shNext    = w_head;
            w_outNext   = 1'b0;
            w_stateNext = START;
          end else begin
            w_stateNext = IDLE;
          end
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_osc   <= '0;
      r_idx   <= '0;
      r_sh    <= '0;
      r_out   <= 1'b1;
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_stateNext;
      r_osc   <= w_oscNext;
      r_idx   <= w_idxNext;
      r_sh    <= w_shNext;
      r_out   <= w_outNext;
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
`ifdef UART_TX_PARITY_EN
      if (w_pop) r_par <= ^w_head;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= in;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo with a timeline reference model.
// Honours UART_TX_PARITY_EN to expect 11-bit frames with even parity.
module tb_uart_tx_fifo;

  localparam int O     = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FR = NB * O;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] txData;
  logic       wrStrobe;
  logic       full;
  logic       busy;
  logic       lineOut;

  int total = 0;
  int bad   = 0;
  bit checkEn = 1'b0;

  uart_tx_fifo #(.o(O), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .in  (txData),
    .wr  (wrStrobe),
    .full(full),
    .busy(busy),
    .out (lineOut)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus frame timing worked out from the frame start time
  logic [7:0] mq[$];
  logic [7:0] expQ[$];
  int         mTime = 0;
  int         frameStart = -FR;
  int         nextFree = 0;
  int         age;
  logic [7:0] curByte = 8'h00;
  logic       fullPre;
  logic       expOut = 1'b1;
  logic       expBusy = 1'b0;
  logic       expFull = 1'b0;

  function automatic logic frameBit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (NB == 11 && k == 9) return ^b;
    return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      expQ.delete();
      frameStart = mTime - FR;
      nextFree   = mTime;
    end else begin
      mTime++;
      fullPre = (mq.size() == DEPTH);
      if (mq.size() != 0 && mTime >= nextFree) begin
        curByte    = mq.pop_front();
        frameStart = mTime;
        nextFree   = mTime + FR;
      end
      if (wrStrobe && !fullPre) begin
        mq.push_back(txData);
        expQ.push_back(txData);
      end
    end
    age     = mTime - frameStart;
    expOut  = (age >= 0 && age < FR) ? frameBit(curByte, age / O) : 1'b1;
    expBusy = (age < FR) || (mq.size() != 0);
    expFull = (mq.size() == DEPTH);
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("out", lineOut, expOut);
      checkOutput("busy", busy, expBusy);
      checkOutput("full", full, expFull);
    end
  end

  // Monitor: decodes frames from the line mid-bit and pops the scoreboard
  bit         rxOn = 1'b0;
  int         rxCnt;
  int         rxBit;
  logic [7:0] rxByte;
  logic [7:0] expByte;
`ifdef UART_TX_PARITY_EN
  logic       rxPar;
`endif

  always @(negedge clk) begin
    if (rst) begin
      rxOn = 1'b0;
    end else if (!rxOn) begin
      if (lineOut === 1'b0) begin
        rxOn  = 1'b1;
        rxCnt = 0;
      end
    end else begin
      rxCnt++;
      if (rxCnt % O == O / 2) begin
        rxBit = rxCnt / O;
        if (rxBit >= 1 && rxBit <= 8) begin
          rxByte[rxBit-1] = lineOut;
        end else if (rxBit == NB - 1) begin
          checkOutput("stopBit", lineOut, 1'b1);
          if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL rxFrame actual=%02h required=no_frame", rxByte);
          end else begin
            expByte = expQ.pop_front();
            checkOutput("rxByte", rxByte, expByte);
`ifdef UART_TX_PARITY_EN
            checkOutput("parity", rxPar, ^expByte);
`endif
          end
          rxOn = 1'b0;
        end else begin
`ifdef UART_TX_PARITY_EN
          rxPar = lineOut;
`endif
        end
      end
    end
  end

  task automatic applyStimulus(input logic w, input logic [7:0] d);
    wrStrobe = w;
    txData   = d;
    @(negedge clk);
  endtask

  task automatic waitIdle(input int limit, output int n);
    wrStrobe = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idleReached", busy, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    rst = 1'b0;
    wrStrobe = 1'b0;
    txData = 8'h00;
    #2 rst = 1'b1;
    #1 checkEn = 1'b1;
    checkOutput("rstOut", lineOut, 1'b1);
    checkOutput("rstBusy", busy, 1'b0);
    checkOutput("rstFull", full, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // single frame, busy lasts the write edge plus one full frame
    applyStimulus(1'b1, 8'h55);
    waitIdle(200, n);
    checkOutput("busyLen", n, FR + 1);

    // overrun: sixth byte is refused
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(1'b1, 8'(i));
      if (i == 5) checkOutput("fullAfter5", full, 1'b1);
    end
    checkOutput("fullAfter6", full, 1'b1);
    waitIdle(1000, n);

    // write into full FIFO on the pop edge is refused
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'h11 + 8'(i));
    repeat (FR - 4) applyStimulus(1'b0, 8'h00);
    checkOutput("fullBeforePop", full, 1'b1);
    applyStimulus(1'b1, 8'h99);
    checkOutput("fullAfterPop", full, 1'b0);
    waitIdle(1000, n);

    // write on the last stop clock into an empty FIFO: one idle clock then start
    applyStimulus(1'b1, 8'hAA);
    repeat (FR) applyStimulus(1'b0, 8'h00);
    applyStimulus(1'b1, 8'h3C);
    checkOutput("gapHigh", lineOut, 1'b1);
    checkOutput("gapBusy", busy, 1'b1);
    applyStimulus(1'b0, 8'h00);
    checkOutput("startAfterGap", lineOut, 1'b0);
    waitIdle(500, n);

    // asynchronous reset in the middle of data bit 3
    applyStimulus(1'b1, 8'hA0);
    repeat (18) applyStimulus(1'b0, 8'h00);
    checkOutput("preRstBit3", lineOut, 1'b0);
    #1 rst = 1'b1;
    #1;
    checkOutput("midRstOut", lineOut, 1'b1);
    checkOutput("midRstBusy", busy, 1'b0);
    checkOutput("midRstFull", full, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (60) applyStimulus(1'b0, 8'h00);
    checkOutput("noTxAfterRst", busy, 1'b0);

`ifdef UART_TX_PARITY_EN
    applyStimulus(1'b1, 8'h07);
    applyStimulus(1'b1, 8'h03);
    waitIdle(500, n);
`endif

    // random traffic
    repeat (400) applyStimulus($urandom_range(0, 2) == 0, 8'($urandom));
    waitIdle(4000, n);

    checkOutput("scoreboardEmpty", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
